// File: rtl/alu_mc.sv
// Multi-cycle execute-stage ALU: single-cycle logic/arith/shift/compare ops plus
// iterative shift-add multiply and restoring divide behind a Start/Busy/Done handshake.
module alu_mc #(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             Start,
    input  logic [3:0]       ALUControl,
    input  logic [WIDTH-1:0] SrcA,
    input  logic [WIDTH-1:0] SrcB,
    output logic [WIDTH-1:0] Result,
    output logic [WIDTH-1:0] ResultHi,
    output logic             Zero,
    output logic             Busy,
    output logic             Done
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [WIDTH-1:0] result_hi_q, result_hi_d;
    logic             zero_q, zero_d;
    logic [WIDTH-1:0] acc_hi_q, acc_hi_d;
    logic [WIDTH-1:0] acc_lo_q, acc_lo_d;
    logic [WIDTH-1:0] opnd_q, opnd_d;
    logic             is_div_q, is_div_d;
    logic [CW-1:0]    cnt_q, cnt_d;

    logic [WIDTH-1:0] alu_y;
    logic [SHW-1:0]   sh;
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   rem_sh;
    logic [WIDTH:0]   trial;
    logic [WIDTH-1:0] step_hi, step_lo;

    assign sh = SrcA[SHW-1:0];

    always_comb begin
        alu_y = '0;
        case (ALUControl)
            4'd0:  alu_y = SrcA & SrcB;
            4'd1:  alu_y = SrcA | SrcB;
            4'd2:  alu_y = SrcA + SrcB;
            4'd3:  alu_y = SrcA - SrcB;
            4'd4:  alu_y = SrcB << sh;
            4'd5:  alu_y = SrcB >> sh;
            4'd6:  alu_y = {{(WIDTH-1){1'b0}}, (SrcA < SrcB)};
            4'd7:  alu_y = SrcB << (WIDTH / 2);
            4'd8:  alu_y = $unsigned($signed(SrcB) >>> sh);
            4'd9:  alu_y = {{(WIDTH-1){1'b0}}, ($signed(SrcA) < $signed(SrcB))};
            4'd10: alu_y = SrcA ^ SrcB;
            4'd11: alu_y = ~(SrcA | SrcB);
            default: alu_y = '0;
        endcase
    end

    // Multiply keeps {hi, lo} as the product with the multiplier shifting out of lo;
    // divide keeps the partial remainder in hi and shifts the dividend/quotient through lo.
    always_comb begin
        mul_sum = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, opnd_q} : '0);
        rem_sh  = {acc_hi_q, acc_lo_q[WIDTH-1]};
        trial   = rem_sh - {1'b0, opnd_q};
        if (is_div_q) begin
            if (!trial[WIDTH]) begin
                step_hi = trial[WIDTH-1:0];
                step_lo = {acc_lo_q[WIDTH-2:0], 1'b1};
            end else begin
                step_hi = rem_sh[WIDTH-1:0];
                step_lo = {acc_lo_q[WIDTH-2:0], 1'b0};
            end
        end else begin
            step_hi = mul_sum[WIDTH:1];
            step_lo = {mul_sum[0], acc_lo_q[WIDTH-1:1]};
        end
    end

    always_comb begin
        state_d     = state_q;
        result_d    = result_q;
        result_hi_d = result_hi_q;
        zero_d      = zero_q;
        acc_hi_d    = acc_hi_q;
        acc_lo_d    = acc_lo_q;
        opnd_d      = opnd_q;
        is_div_d    = is_div_q;
        cnt_d       = cnt_q;
        case (state_q)
            RUN: begin
                acc_hi_d = step_hi;
                acc_lo_d = step_lo;
                cnt_d    = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    result_d    = step_lo;
                    result_hi_d = step_hi;
                    zero_d      = (step_lo == '0);
                    state_d     = DONE;
                end
            end
            default: begin
                state_d = IDLE;
                if (Start) begin
                    if (ALUControl == 4'd12 || ALUControl == 4'd13) begin
                        is_div_d = (ALUControl == 4'd13);
                        opnd_d   = (ALUControl == 4'd13) ? SrcB : SrcA;
                        acc_lo_d = (ALUControl == 4'd13) ? SrcA : SrcB;
                        acc_hi_d = '0;
                        cnt_d    = CW'(WIDTH);
                        state_d  = RUN;
                    end else begin
                        result_d    = alu_y;
                        result_hi_d = '0;
                        zero_d      = (alu_y == '0);
                        state_d     = DONE;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            result_q    <= '0;
            result_hi_q <= '0;
            zero_q      <= 1'b1;
            acc_hi_q    <= '0;
            acc_lo_q    <= '0;
            opnd_q      <= '0;
            is_div_q    <= 1'b0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            result_q    <= result_d;
            result_hi_q <= result_hi_d;
            zero_q      <= zero_d;
            acc_hi_q    <= acc_hi_d;
            acc_lo_q    <= acc_lo_d;
            opnd_q      <= opnd_d;
            is_div_q    <= is_div_d;
            cnt_q       <= cnt_d;
        end
    end

    assign Result   = result_q;
    assign ResultHi = result_hi_q;
    assign Zero     = zero_q;
    assign Busy     = (state_q == RUN);
    assign Done     = (state_q == DONE);
endmodule

// File: tb/tb_alu_mc.sv
// Directed bench for alu_mc: a 32-bit and a 16-bit instance driven on the falling edge
// and checked on the falling edge against hand-computed values.
module tb_alu_mc;
    logic        clk = 1'b0;
    logic        reset = 1'b1;

    logic        start32 = 1'b0;
    logic [3:0]  ctl32 = '0;
    logic [31:0] a32 = '0, b32 = '0;
    logic [31:0] res32, hi32;
    logic        zero32, busy32, done32;

    logic        start16 = 1'b0;
    logic [3:0]  ctl16 = '0;
    logic [15:0] a16 = '0, b16 = '0;
    logic [15:0] res16, hi16;
    logic        zero16, busy16, done16;

    int total = 0;
    int bad = 0;
    int cyc;

    always #5 clk = ~clk;

    alu_mc #(.WIDTH(32)) dut32 (
        .clk(clk), .reset(reset), .Start(start32), .ALUControl(ctl32),
        .SrcA(a32), .SrcB(b32), .Result(res32), .ResultHi(hi32),
        .Zero(zero32), .Busy(busy32), .Done(done32)
    );

    alu_mc #(.WIDTH(16)) dut16 (
        .clk(clk), .reset(reset), .Start(start16), .ALUControl(ctl16),
        .SrcA(a16), .SrcB(b16), .Result(res16), .ResultHi(hi16),
        .Zero(zero16), .Busy(busy16), .Done(done16)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Called at a falling edge; returns at the falling edge where Done is seen.
    // With mid=1 a stray Start with different operands is pulsed while the op runs.
    task automatic op32(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                        input bit mid, output int n);
        ctl32 = c; a32 = a; b32 = b; start32 = 1'b1;
        @(negedge clk);
        start32 = 1'b0;
        n = 1;
        while (!done32 && n < 100) begin
            if (mid && n == 3) begin
                start32 = 1'b1; ctl32 = 4'd2; a32 = 32'h0; b32 = 32'h0;
            end else begin
                start32 = 1'b0;
            end
            @(negedge clk);
            n++;
        end
        start32 = 1'b0;
    endtask

    task automatic op16(input logic [3:0] c, input logic [15:0] a, input logic [15:0] b,
                        output int n);
        ctl16 = c; a16 = a; b16 = b; start16 = 1'b1;
        @(negedge clk);
        start16 = 1'b0;
        n = 1;
        while (!done16 && n < 100) begin
            @(negedge clk);
            n++;
        end
    endtask

    initial begin
        #12;
        chk("rst_result", res32, 0);
        chk("rst_hi", hi32, 0);
        chk("rst_zero", zero32, 1);
        chk("rst_busy", busy32, 0);
        chk("rst_done", done32, 0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        op32(4'd2, 32'hFFFF_FFFF, 32'h1, 0, cyc);
        chk("add_lat", cyc, 1);
        chk("add_res", res32, 0);
        chk("add_zero", zero32, 1);
        op32(4'd3, 32'd5, 32'd7, 0, cyc);
        chk("sub_b2b_lat", cyc, 1);
        chk("sub_res", res32, 32'hFFFF_FFFE);
        chk("sub_zero", zero32, 0);
        @(negedge clk);
        chk("hold_done", done32, 0);
        chk("hold_res", res32, 32'hFFFF_FFFE);

        op32(4'd4, 32'h24, 32'h8000_0010, 0, cyc);
        chk("sll", res32, 32'h0000_0100);
        op32(4'd5, 32'h24, 32'h8000_0010, 0, cyc);
        chk("srl", res32, 32'h0800_0001);
        op32(4'd8, 32'h24, 32'h8000_0010, 0, cyc);
        chk("sra", res32, 32'hF800_0001);
        op32(4'd7, 32'h24, 32'h0000_1234, 0, cyc);
        chk("lui", res32, 32'h1234_0000);
        op32(4'd9, 32'hFFFF_FFFF, 32'h1, 0, cyc);
        chk("slt", res32, 1);
        op32(4'd6, 32'hFFFF_FFFF, 32'h1, 0, cyc);
        chk("sltu", res32, 0);
        chk("sltu_zero", zero32, 1);
        op32(4'd10, 32'h0000_F0F0, 32'h0000_FF00, 0, cyc);
        chk("xor", res32, 32'h0000_0FF0);
        op32(4'd11, 32'h0, 32'h0, 0, cyc);
        chk("nor", res32, 32'hFFFF_FFFF);
        op32(4'd0, 32'hFF00_FF00, 32'h0FF0_0FF0, 0, cyc);
        chk("and", res32, 32'h0F00_0F00);
        op32(4'd1, 32'hFF00_0000, 32'h0000_00FF, 0, cyc);
        chk("or", res32, 32'hFF00_00FF);

        op32(4'd12, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, cyc);
        chk("mulu_lat", cyc, 33);
        chk("mulu_lo", res32, 32'h0000_0001);
        chk("mulu_hi", hi32, 32'hFFFF_FFFE);
        op32(4'd14, 32'h1234, 32'h5678, 0, cyc);
        chk("rsvd_res", res32, 0);
        chk("rsvd_hi", hi32, 0);
        chk("rsvd_zero", zero32, 1);

        op32(4'd13, 32'd100, 32'd7, 0, cyc);
        chk("divu_lat", cyc, 33);
        chk("divu_q", res32, 14);
        chk("divu_r", hi32, 2);
        op32(4'd13, 32'd9, 32'd0, 0, cyc);
        chk("div0_lat", cyc, 33);
        chk("div0_q", res32, 32'hFFFF_FFFF);
        chk("div0_r", hi32, 9);

        op16(4'd13, 16'd100, 16'd7, cyc);
        chk("d16_lat", cyc, 17);
        chk("d16_q", res16, 14);
        chk("d16_r", hi16, 2);
        op16(4'd13, 16'd9, 16'd0, cyc);
        chk("d16z_lat", cyc, 17);
        chk("d16z_q", res16, 16'hFFFF);
        chk("d16z_r", hi16, 9);
        op16(4'd12, 16'hFFFF, 16'h0003, cyc);
        chk("m16_lo", res16, 16'hFFFD);
        chk("m16_hi", hi16, 16'h0002);

        @(negedge clk);
        op32(4'd12, 32'h1234_5678, 32'h9, 0, cyc);
        chk("pre_rst_res", res32, 32'hA3D7_0A38);
        chk("pre_rst_hi", hi32, 32'h0000_0000);
        ctl32 = 4'd12; a32 = 32'h7; b32 = 32'h3; start32 = 1'b1;
        @(negedge clk);
        start32 = 1'b0;
        repeat (4) @(negedge clk);
        chk("mid_busy", busy32, 1);
        #1 reset = 1'b1;
        #1;
        chk("arst_busy", busy32, 0);
        chk("arst_done", done32, 0);
        chk("arst_res", res32, 0);
        chk("arst_zero", zero32, 1);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        op32(4'd2, 32'd3, 32'd4, 0, cyc);
        chk("post_rst_lat", cyc, 1);
        chk("post_rst_res", res32, 7);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
